iobus_sseg_scan_ctrl: RTL and testbench
=======================================

// Module: iobus_sseg_scan_ctrl
// PURPOSE
//  IOBUS-mapped controller for the 4-digit 7-segment display. Owns the display:
//  the MCU writes a 16-bit hex value and a control word; the block time-multiplexes
//  the anodes, decodes nibbles and drives segs/an directly.
//  Sits beside the wrapper's output-port logic. It replaces the software-driven
//  SEGS/ANODES registers. Readback feeds the wrapper's IOBUS_IN mux.
// PARAMETERS
//  DATA_ADDR    32'h1100C010  display value register (16 bits used)
//  CTRL_ADDR    32'h1100C014  control register (8 bits used)
//  REFRESH_DIV  50000         clk cycles per digit slot (>= 4)
//  GAP_CYC      64            all-anodes-off cycles at end of each slot (< REFRESH_DIV)
// PORTS
//  clk         in   1   system clock (same clock as the MCU)
//  RESET_N     in   1   asynchronous reset, active-low
//  IOBUS_ADDR  in   32  bus address from MCU
//  IOBUS_OUT   in   32  bus write data from MCU
//  IOBUS_WR    in   1   bus write strobe
//  rd_data     out  32  readback for the IOBUS_IN mux (combinational)
//  rd_hit      out  1   IOBUS_ADDR matches DATA_ADDR or CTRL_ADDR (combinational)
//  segs        out  8   cathodes, active-low: [0]=CA ... [6]=CG, [7]=DP
//  an          out  4   anodes, active-low: an[0] = rightmost digit
// BEHAVIOUR
//  - Reset (async, RESET_N=0): data_r=0, ctrl_r=0, shadow=0, cnt=0, state=OFF,
//    segs=8'hFF, an=4'hF. Outputs stay blank until ctrl.EN=1.
//  - Writes: on posedge clk with IOBUS_WR=1.
//    - Address DATA_ADDR: data_r <= IOBUS_OUT[15:0].
//    - Address CTRL_ADDR: ctrl_r <= IOBUS_OUT[7:0], with bits [3:2] forced to 0.
//    - Other addresses: ignored.
//  - ctrl_r bits: [0] EN, [1] BLZ (blank leading zeros), [3:2] reserved (0),
//    [7:4] DP mask (bit 4+k lights the DP of digit k).
//  - Readback:
//    - Address DATA_ADDR: rd_data = {16'b0, data_r}.
//    - Address CTRL_ADDR: rd_data = {24'b0, ctrl_r}.
//    - Otherwise: rd_data = 0 and rd_hit = 0.
//  - FSM states: OFF, DIG0, DIG1, DIG2, DIG3.
//    - OFF -> DIG0 on the first clock after EN=1 is seen. cnt=0 and shadow <= data_r.
//    - DIGk: cnt counts 0..REFRESH_DIV-1. At cnt==REFRESH_DIV-1, advance to DIG(k+1)
//      and clear cnt.
//    - DIG3 -> DIG0 wraps, and shadow <= data_r (frame boundary, no tearing).
//    - EN=0 in any DIG state: next clock goes to OFF and cnt is cleared.
//  - Slot output: digit k is lit while cnt < REFRESH_DIV-GAP_CYC, then an=4'hF
//    for GAP_CYC cycles (anti-ghosting).
//  - segs/an are registered: they lag the state/cnt by exactly 1 clk. In OFF both
//    outputs are all-ones.
//  - Decode: nibble shadow[4k+3:4k] is mapped to hex 0-F glyphs.
//    - DP = ctrl[4+k], independent of blanking.
//  - BLZ=1: digit 3 blanks if nib3==0. Digit 2 blanks if nib3==0 and nib2==0.
//    Digit 1 blanks if nib3, nib2 and nib1 are all 0. Digit 0 never blanks.
//    - A blanked digit has segs[6:0]=7'h7F. Its anode is still driven.
//  - DATA write on the same edge as a DIG3->DIG0 wrap: shadow takes the OLD data_r.
//    The new value shows from the following frame.
//  - CTRL write affecting BLZ/DP: takes effect on the next output register update,
//    not deferred to the frame boundary.
//  - Reset mid-scan: immediate blank (an=4'hF), state OFF.
//  - Counter width: $clog2(REFRESH_DIV). No overflow is possible.
// STRUCTURE
//  - Package sseg_pkg holds:
//    - scan_state_t enum (OFF, DIG0..DIG3);
//    - default address localparams;
//    - CTRL bit index constants (EN=0, BLZ=1, DP_LSB=4);
//    - SEG_BLANK=8'hFF and AN_OFF=4'hF.
//  - Sub-module hex_to_sseg: combinational, 4-bit nibble in, 7-bit active-low
//    CA..CG out. 0 -> 7'b1000000, F -> 7'b0001110.
// TESTING  (bench uses REFRESH_DIV=8, GAP_CYC=2)
//  1. Reset, then 20 clks idle -> an=4'hF and segs=8'hFF throughout;
//     rd_data at CTRL_ADDR = 0.
//  2. Write DATA=16'h12AF, then CTRL=8'h01 -> from the 2nd clk, an=4'b1110 for 6 clks
//     with segs=8'h8E ('F'), then an=4'hF for 2 clks, then an=4'b1101 with 'A';
//     full order 0,1,2,3 and repeat.
//  3. DATA=16'h0005, CTRL=8'h03 (BLZ) -> digits 3, 2, 1 show segs=8'hFF while their
//     anode is low; digit 0 shows '5' (8'h92).
//  4. CTRL=8'h81 -> digit 3 DP low (segs[7]=0) only in the DIG3 slot; the other
//     slots have segs[7]=1.
//  5. Write DATA=16'hBEEF mid-frame during DIG1 -> the current frame keeps the old
//     digits; BEEF appears starting at the next DIG0. Also write on the exact wrap
//     edge -> delayed one frame.
//  6. Drop EN mid-DIG2 -> an=4'hF 2 clks later. Pulse RESET_N low mid-scan ->
//     an=4'hF immediately (async); data_r reads back 0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and constants for the IOBUS 7-segment scan controller:
// scan states, default bus addresses, control bit positions and idle patterns.
package sseg_pkg;

    typedef enum logic [2:0] {
        OFF,
        DIG0,
        DIG1,
        DIG2,
        DIG3
    } scan_state_t;

    localparam logic [31:0] DEF_DATA_ADDR = 32'h1100C010;
    localparam logic [31:0] DEF_CTRL_ADDR = 32'h1100C014;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_BLZ    = 1;
    localparam int CTRL_DP_LSB = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    function automatic scan_state_t next_digit(input scan_state_t s);
        case (s)
            DIG0:    return DIG1;
            DIG1:    return DIG2;
            DIG2:    return DIG3;
            default: return DIG0;
        endcase
    endfunction

    function automatic logic [1:0] digit_index(input scan_state_t s);
        case (s)
            DIG1:    return 2'd1;
            DIG2:    return 2'd2;
            DIG3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Hex nibble to active-low 7-segment glyph, bit order {CG,CF,CE,CD,CC,CB,CA}.
module hex_to_sseg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/iobus_sseg_scan_ctrl.sv
// IOBUS-mapped 4-digit 7-segment controller: value/control registers, anode
// scan FSM with anti-ghosting gap, per-frame shadow of the displayed value.
module iobus_sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter logic [31:0] DATA_ADDR   = DEF_DATA_ADDR,
    parameter logic [31:0] CTRL_ADDR   = DEF_CTRL_ADDR,
    parameter int          REFRESH_DIV = 50000,
    parameter int          GAP_CYC     = 64
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic [7:0]  segs,
    output logic [3:0]  an
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(REFRESH_DIV - GAP_CYC);

    logic [15:0]      data_q, data_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    scan_state_t      state_q, state_d;
    logic [7:0]       segs_q, segs_d;
    logic [3:0]       an_q, an_d;

    logic       data_hit, ctrl_hit;
    logic [1:0] dig;
    logic [3:0] nib;
    logic [6:0] glyph;
    logic [3:0] dp_mask;
    logic       lead_zero;
    logic       unused_bits;

    assign data_hit    = (IOBUS_ADDR == DATA_ADDR);
    assign ctrl_hit    = (IOBUS_ADDR == CTRL_ADDR);
    assign unused_bits = ^{IOBUS_OUT[31:16], IOBUS_OUT[3:2]};

    always_comb begin
        rd_hit  = data_hit || ctrl_hit;
        rd_data = '0;
        if (data_hit)      rd_data = {16'b0, data_q};
        else if (ctrl_hit) rd_data = {24'b0, ctrl_q};
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        shadow_d = shadow_q;
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (IOBUS_WR && data_hit) data_d = IOBUS_OUT[15:0];
        if (IOBUS_WR && ctrl_hit) ctrl_d = {IOBUS_OUT[7:4], 2'b00, IOBUS_OUT[1:0]};

        if (!ctrl_q[CTRL_EN]) begin
            state_d = OFF;
            cnt_d   = '0;
        end else if (state_q == OFF) begin
            state_d  = DIG0;
            cnt_d    = '0;
            shadow_d = data_q;
        end else if (cnt_q == CNT_LAST) begin
            state_d = next_digit(state_q);
            cnt_d   = '0;
            // Shadow reloads only on the frame wrap so a frame never mixes two values.
            if (state_q == DIG3) shadow_d = data_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign dig     = digit_index(state_q);
    assign nib     = shadow_q[{dig, 2'b00} +: 4];
    assign dp_mask = ctrl_q[CTRL_DP_LSB +: 4];

    hex_to_sseg u_hex (
        .nibble (nib),
        .seg    (glyph)
    );

    always_comb begin
        lead_zero = 1'b0;
        if (ctrl_q[CTRL_BLZ]) begin
            case (dig)
                2'd3:    lead_zero = (shadow_q[15:12] == 4'h0);
                2'd2:    lead_zero = (shadow_q[15:8] == 8'h00);
                2'd1:    lead_zero = (shadow_q[15:4] == 12'h000);
                default: lead_zero = 1'b0;
            endcase
        end

        segs_d = SEG_BLANK;
        an_d   = AN_OFF;
        if (state_q != OFF && cnt_q < CNT_LIT) begin
            an_d   = ~(4'b0001 << dig);
            segs_d = {~dp_mask[dig], lead_zero ? 7'h7F : glyph};
        end
    end

    // NOTE: state flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            data_q   <= '0;
            ctrl_q   <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            state_q  <= OFF;
            segs_q   <= SEG_BLANK;
            an_q     <= AN_OFF;
        end else begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            segs_q   <= segs_d;
            an_q     <= an_d;
        end
    end

    assign segs = segs_q;
    assign an   = an_q;

endmodule

// File: tb/tb_iobus_sseg_scan_ctrl.sv
// Directed bench for iobus_sseg_scan_ctrl: expected anode/segment pairs are
// queued per cycle when stimulus is issued and popped as the DUT scans.
module tb_iobus_sseg_scan_ctrl;

    localparam logic [31:0] DATA_A = 32'h1100C010;
    localparam logic [31:0] CTRL_A = 32'h1100C014;

    logic        clk        = 1'b0;
    logic        RESET_N    = 1'b0;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT  = '0;
    logic        IOBUS_WR   = 1'b0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [7:0]  segs;
    logic [3:0]  an;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] segs;
    } out_t;

    out_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string phase = "init";

    iobus_sseg_scan_ctrl #(
        .DATA_ADDR   (DATA_A),
        .CTRL_ADDR   (CTRL_A),
        .REFRESH_DIV (8),
        .GAP_CYC     (2)
    ) dut (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .segs       (segs),
        .an         (an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached in phase %s", phase);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_blank(input int n);
        for (int i = 0; i < n; i++) sb.push_back('{an: 4'hF, segs: 8'hFF});
    endtask

    // One frame at REFRESH_DIV=8, GAP_CYC=2: 6 lit cycles then 2 dark per digit.
    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] sv[4];
        logic [3:0] an_e;
        sv = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) begin
            an_e = ~(4'b0001 << k);
            for (int c = 0; c < 6; c++) sb.push_back('{an: an_e, segs: sv[k]});
            push_blank(2);
        end
    endtask

    task automatic trim(input int keep);
        while (sb.size() > keep) void'(sb.pop_back());
    endtask

    task automatic step_check(input int j);
        out_t e;
        tick();
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s[%0d]: observed empty scoreboard expected an entry", phase, j);
        end else begin
            e = sb.pop_front();
            chk($sformatf("%s[%0d].an", phase, j), {28'b0, an}, {28'b0, e.an});
            chk($sformatf("%s[%0d].segs", phase, j), {24'b0, segs}, {24'b0, e.segs});
        end
    endtask

    task automatic drain(input int n);
        for (int j = 0; j < n; j++) step_check(j);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
    endtask

    // Disable, load the value, enable: the scan then starts from DIG0 with a clean shadow.
    task automatic start(input logic [15:0] value, input logic [7:0] ctrl);
        bus_write(CTRL_A, 32'h0);
        bus_write(DATA_A, {16'b0, value});
        bus_write(CTRL_A, {24'b0, ctrl});
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_data, input logic exp_hit);
        IOBUS_ADDR = addr;
        #1;
        chk({tag, ".data"}, rd_data, exp_data);
        chk({tag, ".hit"}, {31'b0, rd_hit}, {31'b0, exp_hit});
        IOBUS_ADDR = '0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 RESET_N = 1'b1;
        tick();

        phase = "reset_idle";
        push_blank(20);
        drain(20);
        read_check("rd_ctrl_reset", CTRL_A, 32'h0, 1'b1);
        read_check("rd_other", 32'h1100C018, 32'h0, 1'b0);

        phase = "hex_12AF";
        start(16'h12AF, 8'h01);
        push_blank(1);
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
        drain(65);
        read_check("rd_data_12AF", DATA_A, 32'h0000_12AF, 1'b1);
        read_check("rd_ctrl_01", CTRL_A, 32'h0000_0001, 1'b1);

        phase = "blz_0005";
        start(16'h0005, 8'h03);
        push_blank(1);
        push_frame(8'h92, 8'hFF, 8'hFF, 8'hFF);
        drain(33);

        phase = "dp3_0005";
        start(16'h0005, 8'h81);
        push_blank(1);
        push_frame(8'h92, 8'hC0, 8'hC0, 8'h40);
        drain(33);

        phase = "shadow";
        start(16'h12AF, 8'h01);
        push_blank(1);
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
        push_frame(8'h8E, 8'h86, 8'h86, 8'h83);
        push_frame(8'h8E, 8'h86, 8'h86, 8'h83);
        push_frame(8'hB0, 8'hA4, 8'hF9, 8'hC0);
        for (int j = 0; j < 129; j++) begin
            step_check(j);
            if (j == 11 || j == 63) begin
                IOBUS_ADDR = DATA_A;
                IOBUS_OUT  = (j == 11) ? 32'h0000_BEEF : 32'h0000_0123;
                IOBUS_WR   = 1'b1;
            end
            if (j == 12 || j == 64) begin
                IOBUS_WR   = 1'b0;
                IOBUS_ADDR = '0;
                IOBUS_OUT  = '0;
            end
        end

        phase = "en_drop";
        start(16'h12AF, 8'h01);
        push_blank(1);
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
        trim(22);
        push_blank(3);
        for (int j = 0; j < 25; j++) begin
            step_check(j);
            if (j == 19) begin
                IOBUS_ADDR = CTRL_A;
                IOBUS_OUT  = 32'h0;
                IOBUS_WR   = 1'b1;
            end
            if (j == 20) begin
                IOBUS_WR   = 1'b0;
                IOBUS_ADDR = '0;
            end
        end

        phase = "async_reset";
        start(16'h12AF, 8'h01);
        push_blank(1);
        push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
        trim(11);
        drain(11);
        #1 RESET_N = 1'b0;
        #1;
        chk("async_reset.an", {28'b0, an}, 32'h0000_000F);
        chk("async_reset.segs", {24'b0, segs}, 32'h0000_00FF);
        #2 RESET_N = 1'b1;
        read_check("rd_data_after_reset", DATA_A, 32'h0, 1'b1);
        read_check("rd_ctrl_after_reset", CTRL_A, 32'h0, 1'b1);

        phase = "ctrl_reserved";
        bus_write(CTRL_A, 32'h0000_00FC);
        read_check("rd_ctrl_reserved", CTRL_A, 32'h0000_00F0, 1'b1);
        push_blank(4);
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
